// File: rtl/i2c_target_if.sv
// i2c_target_if: user-side data interface of the I2C target.
// Signals: tx_data (read payload into the target), rx_data/rx_valid/rx_index
//          (received write bytes), rd_start (read address accepted), busy.
// Modports: slave = the target, master = the FPGA-side logic using it.
interface i2c_target_if;
   logic [15:0] tx_data;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_index;
   logic        rd_start;
   logic        busy;

   modport slave  (input  tx_data, output rx_data, rx_valid, rx_index, rd_start, busy);
   modport master (output tx_data, input  rx_data, rx_valid, rx_index, rd_start, busy);
endinterface

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C responder supporting 1-2 byte writes and reads.
// Ports: clk, rst_n (synchronous, active low); SCL bus clock input (never stretched);
//        SDA open-drain bus data (driven 0 or z only);
//        user_if (slave): tx_data in, rx_data/rx_valid/rx_index/rd_start/busy out.
module i2c_target #(
   parameter logic [6:0]  DEV_ADDR    = 7'h48,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SCL,
   inout  wire         SDA,
   i2c_target_if.slave user_if
);
   localparam int unsigned BIT_CNT_W  = 4;
   localparam int unsigned BYTE_CNT_W = 2;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, IGNORE, RX_BYTE, RX_ACK, RX_NACK, TX_BYTE, TX_ACK, WAIT_STOP
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_hist_q, sda_hist_q;
   logic                   scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall;
   logic                   start_det, stop_det;

   state_e                 state_q, state_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             tx_lo_q, tx_lo_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rw_q, rw_d;
   logic                   slot_q, slot_d;
   logic                   sda_oe_q, sda_oe_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   rx_index_q, rx_index_d;
   logic                   rd_start_q, rd_start_d;
   logic                   busy_q, busy_d;

   // Open-drain driver: only ever pulls low.
   assign SDA = sda_oe_q ? 1'b0 : 1'bz;

   assign user_if.rx_data  = rx_data_q;
   assign user_if.rx_valid = rx_valid_q;
   assign user_if.rx_index = rx_index_q;
   assign user_if.rd_start = rd_start_q;
   assign user_if.busy     = busy_q;

   // Bus synchronisers plus history flop; reset to the idle-high bus level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
         scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
         sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s & scl_hist_q;
   assign sda_rise  = sda_s & ~sda_hist_q;
   assign sda_fall  = ~sda_s & sda_hist_q;
   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         tx_lo_q    <= '0;
         rx_data_q  <= '0;
         rw_q       <= 1'b0;
         slot_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_index_q <= 1'b0;
         rd_start_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         tx_lo_q    <= tx_lo_d;
         rx_data_q  <= rx_data_d;
         rw_q       <= rw_d;
         slot_q     <= slot_d;
         sda_oe_q   <= sda_oe_d;
         rx_valid_q <= rx_valid_d;
         rx_index_q <= rx_index_d;
         rd_start_q <= rd_start_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic; bus conditions override any bit activity in the same clk.
   // slot_q marks the second half of an ACK slot (first scl_fall already seen).
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      tx_lo_d    = tx_lo_q;
      rx_data_d  = rx_data_q;
      rw_d       = rw_q;
      slot_d     = slot_q;
      sda_oe_d   = sda_oe_q;
      rx_valid_d = 1'b0;
      rx_index_d = rx_index_q;
      rd_start_d = 1'b0;
      busy_d     = busy_q;

      if (start_det) begin
         state_d    = ADDR;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         slot_d     = 1'b0;
         sda_oe_d   = 1'b0;
      end else if (stop_det) begin
         state_d  = IDLE;
         slot_d   = 1'b0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == BIT_CNT_W'(7)) begin
                     // shift_q[6:0] holds the address; sda_s is R/W. Address 0 never matches.
                     if ((shift_q[6:0] == DEV_ADDR) && (DEV_ADDR != 7'd0)) begin
                        rw_d    = sda_s;
                        busy_d  = 1'b1;
                        slot_d  = 1'b0;
                        state_d = ADDR_ACK;
                     end else begin
                        busy_d  = 1'b0;
                        state_d = IGNORE;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!slot_q) begin
                     slot_d   = 1'b1;
                     sda_oe_d = 1'b1;
                  end else begin
                     slot_d = 1'b0;
                     if (rw_q) begin
                        // ACK ends on the same fall that presents read bit 7.
                        tx_lo_d    = user_if.tx_data[7:0];
                        rd_start_d = 1'b1;
                        sda_oe_d   = ~user_if.tx_data[15];
                        shift_d    = {user_if.tx_data[14:8], 1'b1};
                        bit_cnt_d  = BIT_CNT_W'(1);
                        state_d    = TX_BYTE;
                     end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RX_BYTE;
                     end
                  end
               end
            end
            RX_BYTE: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == BIT_CNT_W'(7)) begin
                     bit_cnt_d = '0;
                     slot_d    = 1'b0;
                     if (byte_cnt_q != BYTE_CNT_W'(2)) begin
                        rx_data_d  = {shift_q[6:0], sda_s};
                        rx_index_d = byte_cnt_q[0];
                        rx_valid_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        state_d    = RX_ACK;
                     end else begin
                        state_d = RX_NACK;
                     end
                  end
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  if (!slot_q) begin
                     slot_d   = 1'b1;
                     sda_oe_d = 1'b1;
                  end else begin
                     slot_d    = 1'b0;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = RX_BYTE;
                  end
               end
            end
            RX_NACK: begin
               sda_oe_d = 1'b0;
               if (scl_fall) begin
                  if (!slot_q) begin
                     slot_d = 1'b1;
                  end else begin
                     slot_d  = 1'b0;
                     state_d = WAIT_STOP;
                  end
               end
            end
            TX_BYTE: begin
               // bit_cnt_q counts bits already placed; the fall after the 8th bit releases SDA.
               if (scl_fall) begin
                  if (bit_cnt_q == BIT_CNT_W'(8)) begin
                     sda_oe_d = 1'b0;
                     state_d  = TX_ACK;
                  end else begin
                     sda_oe_d  = ~shift_q[7];
                     shift_d   = {shift_q[6:0], 1'b1};
                     bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     shift_d    = (byte_cnt_q == BYTE_CNT_W'(0)) ? tx_lo_q : 8'hFF;
                     byte_cnt_d = (byte_cnt_q == BYTE_CNT_W'(2)) ? byte_cnt_q
                                                                 : byte_cnt_q + BYTE_CNT_W'(1);
                     bit_cnt_d  = '0;
                     state_d    = TX_BYTE;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end
            IDLE, IGNORE, WAIT_STOP: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               sda_oe_d = 1'b0;
               state_d  = IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (responder) that answers transactions from an external or on-chip I2C controller on the same two-wire bus.
- Handles 1- or 2-byte writes (controller to target) and 1- or 2-byte reads (target to controller), matching the controller's 16-bit MSB/LSB data framing.
- Drives SDA open-drain only. SCL is input-only; the block never stretches the clock.
- Sits beside the controller in the board-management path, so FPGA-side logic can be exercised and addressed over I2C.

Parameters:
- DEV_ADDR, 7'h48, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop stages synchronising SCL and SDA into clk (minimum 2).

Ports:
- clk  input  1  system clock (100 MHz; at least 8x SCL rate).
- rst_n  input  1  synchronous active-low reset.
- SCL  input  1  bus clock from the controller.
- SDA  inout  1  bus data; the block drives 1'b0 or 1'bz only, never 1'b1.
- tx_data  input  16  read payload: [15:8] is byte 1, [7:0] is byte 2; latched at read-address ACK.
- rx_data  output  8  last byte received in a write.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- rx_index  output  1  0 = first data byte of the write, 1 = second; valid with rx_valid.
- rd_start  output  1  one-clk pulse when a read address is ACKed (tx_data latched the same clk).
- busy  output  1  high from an address match until STOP, or until a START that is not matched.

Behaviour:
- Reset values: SDA released (z); rx_data=0; rx_valid=0; rx_index=0; rd_start=0; busy=0; state=IDLE.
- Input synchronisation:
  - SCL and SDA pass through SYNC_STAGES flops plus one history flop.
  - scl_rise, scl_fall, sda_rise and sda_fall are derived from the synchronised signals only.
- Bus conditions:
  - START = sda_fall while synced SCL is high.
  - STOP = sda_rise while synced SCL is high.
  - Both are recognised in every state, including mid-byte.
  - START (or repeated START) goes to ADDR with the bit counter cleared.
  - STOP releases SDA and goes to IDLE.
- Bit timing: SDA is sampled on scl_rise; the target's SDA output changes only on scl_fall.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits (7 address bits plus R/W). On the 8th scl_rise: if the address equals DEV_ADDR, go to ADDR_ACK; otherwise go to IGNORE.
  - IGNORE: SDA released; busy=0; waits for START or STOP.
  - ADDR_ACK:
    - Drives SDA low from the scl_fall after bit 8 until the next scl_fall.
    - If R/W=1: latch tx_data, pulse rd_start, go to TX_BYTE.
    - If R/W=0: go to RX_BYTE.
    - busy rises at the address match.
  - RX_BYTE: shifts 8 bits MSB first. On the 8th scl_rise, the byte counter decides:
    - byte 0 or 1: rx_data=byte, rx_index=counter, rx_valid pulses 1 clk, go to RX_ACK.
    - byte 2 or later: go to RX_NACK; rx_data is not updated.
  - RX_ACK: drives SDA low for one SCL period (scl_fall to scl_fall), then returns to RX_BYTE.
  - RX_NACK: SDA released for the ACK slot, then WAIT_STOP.
  - TX_BYTE:
    - Outputs byte 1, then byte 2, then 8'hFF for any further bytes, MSB first.
    - Bit n is placed on the scl_fall preceding its clock; a 1 bit means SDA is released.
    - After the 8th bit, SDA is released on scl_fall and the state becomes TX_ACK.
  - TX_ACK: samples controller ACK on scl_rise.
    - SDA=0 (ACK): next byte, TX_BYTE.
    - SDA=1 (NACK): WAIT_STOP.
  - WAIT_STOP: SDA released; waits for STOP (to IDLE) or START (to ADDR).
- Byte counter: 2 bits, saturates at 2; cleared on START.
- Latency: rx_valid rises exactly 1 clk after the synced scl_rise of data bit 0.
- Simultaneous events:
  - START/STOP detection has priority over bit shifting in the same clk.
  - STOP during ADDR_ACK or RX_ACK releases SDA within 1 clk.
- Reset mid-transaction: SDA is released in the same clk rst_n is sampled low. The block ignores the bus until the next START.
- General call (address 0) is not supported and is treated as an address mismatch.

Test Plan:
- Write 2 bytes: START, 0x90, 0xA5, 0x3C, STOP -> three ACKs; rx_valid pulses with rx_data=0xA5/rx_index=0, then 0x3C/rx_index=1; busy falls after STOP.
- Read 2 bytes: tx_data=16'hBEEF; START, 0x91; controller ACKs byte 1 and NACKs byte 2; STOP -> address ACKed, rd_start pulses once, bus carries 0xBE then 0xEF, SDA released after the NACK.
- Address mismatch: START, 0x92, 0x55, STOP -> SDA never driven low, rx_valid=0, busy stays 0.
- Overflow write: START, 0x90, 0x01, 0x02, 0x03, STOP -> bytes 1 and 2 ACKed and reported; byte 3 NACKed with no rx_valid; target returns to IDLE at STOP.
- Repeated START: write 0x90, 0x07, then Sr, 0x91, read 1 byte with NACK, STOP (tx_data=16'h5A00) -> rx_data=0x07 reported, then 0x5A transmitted; byte counter restarts at Sr.
- Reset mid-ACK: assert rst_n=0 while the target drives the address ACK -> SDA=z on the next clk, all outputs at reset values; a subsequent START with 0x90 is ACKed normally.
